pipeline_hazard_ctrl: RTL

Sequencing controller for the four-stage IF/ID/EX/WB integer pipeline. It tracks which stages hold valid instructions and their destination registers, and stalls fetch/decode on read-after-write dependencies. It flushes wrong-path instructions when a branch or jump resolves taken in WB, and drains the pipeline to a halted state on request. It drives the write-enable and flush/bubble inputs of the PC register and the IF/ID, ID/EX and EX/WB buffers.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/dep_check.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the IF/ID/EX/WB pipeline sequencing logic.
package hazard_pkg;

  // Register-specifier width shared with if_id_buf, id_ex_buf and register_file.
  localparam int unsigned REG_ID_W = 6;

  // Controller states.
  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } hazard_state_e;

endpackage

// File: rtl/dep_check.sv
// dep_check: combinational match of one source register against the EX and WB destination
// shadows. A WB-stage writer still counts because the register file writes at the end of WB.
module dep_check #(
  parameter int unsigned REG_ID_W = hazard_pkg::REG_ID_W
) (
  input  logic [REG_ID_W-1:0] src_i,
  input  logic                ex_v_i,
  input  logic                ex_rw_i,
  input  logic [REG_ID_W-1:0] ex_rd_i,
  input  logic                wb_v_i,
  input  logic                wb_rw_i,
  input  logic [REG_ID_W-1:0] wb_rd_i,
  output logic                match_o
);

  // Any valid, writing, older stage whose destination equals the source.
  always_comb begin
    match_o = (ex_v_i & ex_rw_i & (ex_rd_i == src_i)) |
              (wb_v_i & wb_rw_i & (wb_rd_i == src_i));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing controller for the four-stage IF/ID/EX/WB pipeline.
// Tracks stage occupancy and destinations, stalls on RAW hazards, flushes on a taken
// branch resolved in WB and drains to a halted state on request.
// Optional performance counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ID_W = hazard_pkg::REG_ID_W,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic [REG_ID_W-1:0] id_rd,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_regwrt,
  input  logic                wb_branch,
  input  logic                halt_req,
  output logic                pc_write_en,
  output logic                ifid_write_en,
  output logic                ifid_flush,
  output logic                idex_bubble,
  output logic                exwb_flush,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  import hazard_pkg::*;

  hazard_state_e state_q, state_d;

  logic                v_id_q, v_id_d;
  logic                v_ex_q, v_ex_d;
  logic                v_wb_q, v_wb_d;
  logic [REG_ID_W-1:0] ex_rd_q, wb_rd_q;
  logic                ex_rw_q, wb_rw_q;

  logic rs_match, rt_match;
  logic taken, hazard, halted_st;
  logic act_taken, act_drain, act_stall;

  // Unmasked control values; reset forcing is applied only at the ports.
  logic pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c, exwb_flush_c, halted_c;

  dep_check #(
    .REG_ID_W(REG_ID_W)
  ) u_dep_rs (
    .src_i  (id_rs),
    .ex_v_i (v_ex_q),
    .ex_rw_i(ex_rw_q),
    .ex_rd_i(ex_rd_q),
    .wb_v_i (v_wb_q),
    .wb_rw_i(wb_rw_q),
    .wb_rd_i(wb_rd_q),
    .match_o(rs_match)
  );

  dep_check #(
    .REG_ID_W(REG_ID_W)
  ) u_dep_rt (
    .src_i  (id_rt),
    .ex_v_i (v_ex_q),
    .ex_rw_i(ex_rw_q),
    .ex_rd_i(ex_rd_q),
    .wb_v_i (v_wb_q),
    .wb_rw_i(wb_rw_q),
    .wb_rd_i(wb_rd_q),
    .match_o(rt_match)
  );

  // Decode the action for this cycle; priority is taken > halt_req > hazard.
  always_comb begin
    taken     = wb_branch & v_wb_q;
    hazard    = v_id_q & ((id_uses_rs & rs_match) | (id_uses_rt & rt_match));
    halted_st = (state_q == StHalted);
    act_taken = ~halted_st & taken;
    act_drain = ~halted_st & ~taken & halt_req;
    act_stall = ~halted_st & ~taken & ~halt_req & hazard;
  end

  // Buffer and PC controls, decided in the same cycle as the condition.
  always_comb begin
    pc_we_c       = 1'b1;
    ifid_we_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    exwb_flush_c  = 1'b0;
    halted_c      = 1'b0;
    if (halted_st) begin
      pc_we_c       = 1'b0;
      ifid_we_c     = 1'b0;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      exwb_flush_c  = 1'b1;
      halted_c      = 1'b1;
    end else if (act_taken) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      exwb_flush_c  = 1'b1;
    end else if (act_drain) begin
      // No new fetch. A hazarded ID instruction is held rather than overwritten by the
      // IF/ID bubble, so it survives a later halt_req drop and still drains.
      pc_we_c       = 1'b0;
      ifid_flush_c  = 1'b1;
      ifid_we_c     = ~hazard;
      idex_bubble_c = hazard;
    end else if (act_stall) begin
      pc_we_c       = 1'b0;
      ifid_we_c     = 1'b0;
      idex_bubble_c = 1'b1;
    end
  end

  // Port drive: reset forces the safe idle pattern regardless of state.
  always_comb begin
    pc_write_en   = pc_we_c;
    ifid_write_en = ifid_we_c;
    ifid_flush    = ifid_flush_c;
    idex_bubble   = idex_bubble_c;
    exwb_flush    = exwb_flush_c;
    halted        = halted_c;
    if (!reset_n) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      exwb_flush    = 1'b1;
      halted        = 1'b0;
    end
  end

  // Next stage occupancy and state.
  always_comb begin
    v_wb_d  = v_ex_q & ~taken;
    v_ex_d  = v_id_q & ~hazard & ~taken;
    v_id_d  = ifid_we_c ? ~ifid_flush_c : v_id_q;
    state_d = state_q;
    unique case (state_q)
      StHalted: state_d = halt_req ? StHalted : StRun;
      StRun, StStall, StDrain: begin
        if (taken) begin
          state_d = halt_req ? StDrain : StRun;
        end else if (halt_req) begin
          // Halted once nothing remains in flight after this edge.
          state_d = (v_id_d | v_ex_d | v_wb_d) ? StDrain : StHalted;
        end else if (hazard) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
        end
      end
    endcase
  end

  // State, occupancy and destination shadow registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      v_id_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_wb_q  <= 1'b0;
      ex_rd_q <= '0;
      ex_rw_q <= 1'b0;
      wb_rd_q <= '0;
      wb_rw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_id_q  <= v_id_d;
      v_ex_q  <= v_ex_d;
      v_wb_q  <= v_wb_d;
      ex_rd_q <= id_rd;
      ex_rw_q <= id_regwrt;
      wb_rd_q <= ex_rd_q;
      wb_rw_q <= ex_rw_q;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall-cycle and taken-flush counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (act_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CntOne;
      end
      if (act_taken && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CntOne;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
